// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: load, logical/arithmetic shift, rotate,
// clear and hold, with serial inputs at both ends and registered shift-out bits.
module univ_shift_reg #(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             Rn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sr_in,
    input  logic             sl_in,
    output logic [WIDTH-1:0] Q,
    output logic             so_r,
    output logic             so_l,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_r_q, so_r_d;
    logic             so_l_q, so_l_d;
    mode_e            op;

    assign op = mode_e'(mode);

    always_comb begin
        q_d    = q_q;
        so_r_d = so_r_q;
        so_l_d = so_l_q;
        if (en) begin
            case (op)
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_d    = {sr_in, q_q[WIDTH-1:1]};
                    so_r_d = q_q[0];
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sl_in};
                    so_l_d = q_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    q_d    = D;
                    so_r_d = 1'b0;
                    so_l_d = 1'b0;
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    so_r_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_l_d = q_q[WIDTH-1];
                end
                // Sign bit replicates, so negative values settle at all-ones.
                MODE_ASR: begin
                    q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    so_r_d = q_q[0];
                end
                MODE_CLR: begin
                    q_d    = '0;
                    so_r_d = 1'b0;
                    so_l_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            q_q    <= RST_VAL;
            so_r_q <= 1'b0;
            so_l_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            so_r_q <= so_r_d;
            so_l_q <= so_l_d;
        end
    end

    assign Q    = q_q;
    assign so_r = so_r_q;
    assign so_l = so_l_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: an 8-bit instance, a cascaded pair of
// 4-bit instances and a 2-bit instance, checked at every falling clock edge.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    logic Rn;
    always #5 clk = ~clk;

    // 8-bit instance, RST_VAL = A5
    logic       m_en, m_sr, m_sl;
    logic [2:0] m_mode;
    logic [7:0] m_D, m_Q;
    logic       m_so_r, m_so_l, m_zero;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) u_main (
        .clk(clk), .Rn(Rn), .en(m_en), .mode(m_mode), .D(m_D),
        .sr_in(m_sr), .sl_in(m_sl), .Q(m_Q), .so_r(m_so_r), .so_l(m_so_l), .zero(m_zero)
    );

    // Cascaded 4-bit pair forming one 8-bit word {hi, lo}
    logic       c_en, c_lo_sl, c_hi_sr;
    logic [2:0] c_mode;
    logic [3:0] c_lo_D, c_hi_D, lo_Q, hi_Q;
    logic       lo_so_r, lo_so_l, lo_zero, hi_so_r, hi_so_l, hi_zero;

    univ_shift_reg #(.WIDTH(4)) u_lo (
        .clk(clk), .Rn(Rn), .en(c_en), .mode(c_mode), .D(c_lo_D),
        .sr_in(hi_so_r), .sl_in(c_lo_sl), .Q(lo_Q), .so_r(lo_so_r), .so_l(lo_so_l), .zero(lo_zero)
    );
    univ_shift_reg #(.WIDTH(4)) u_hi (
        .clk(clk), .Rn(Rn), .en(c_en), .mode(c_mode), .D(c_hi_D),
        .sr_in(c_hi_sr), .sl_in(lo_so_l), .Q(hi_Q), .so_r(hi_so_r), .so_l(hi_so_l), .zero(hi_zero)
    );

    // 2-bit instance, RST_VAL = 2'b10
    logic       w_en, w_sr, w_sl;
    logic [2:0] w_mode;
    logic [1:0] w_D, w_Q;
    logic       w_so_r, w_so_l, w_zero;

    univ_shift_reg #(.WIDTH(2), .RST_VAL(2'b10)) u_w2 (
        .clk(clk), .Rn(Rn), .en(w_en), .mode(w_mode), .D(w_D),
        .sr_in(w_sr), .sl_in(w_sl), .Q(w_Q), .so_r(w_so_r), .so_l(w_so_l), .zero(w_zero)
    );

    typedef struct {
        int         grp;
        string      name;
        logic [7:0] q;
        logic       sr;
        logic       sl;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: every expectation queued before this falling edge is checked now.
    exp_t       e;
    logic [7:0] a_q;
    logic       a_sr, a_sl, a_z;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.grp)
                0:       begin a_q = m_Q;           a_sr = m_so_r;  a_sl = m_so_l;  a_z = m_zero; end
                1:       begin a_q = {hi_Q, lo_Q};  a_sr = lo_so_r; a_sl = hi_so_l; a_z = hi_zero & lo_zero; end
                default: begin a_q = {6'b0, w_Q};   a_sr = w_so_r;  a_sl = w_so_l;  a_z = w_zero; end
            endcase
            tests++;
            if (a_q !== e.q || a_sr !== e.sr || a_sl !== e.sl || a_z !== e.z) begin
                fails++;
                $display("FAIL %s: got Q=%h so_r=%b so_l=%b zero=%b, expected Q=%h so_r=%b so_l=%b zero=%b",
                         e.name, a_q, a_sr, a_sl, a_z, e.q, e.sr, e.sl, e.z);
            end
        end
    end

    task automatic push(input int g, input string n, input logic [7:0] q,
                        input logic sr, input logic sl, input logic z);
        exp_t x;
        x.grp = g; x.name = n; x.q = q; x.sr = sr; x.sl = sl; x.z = z;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_m(input logic en, input logic [2:0] md, input logic [7:0] d,
                         input logic sr, input logic sl);
        m_en = en; m_mode = md; m_D = d; m_sr = sr; m_sl = sl;
    endtask

    task automatic set_w(input logic en, input logic [2:0] md, input logic sr, input logic sl);
        w_en = en; w_mode = md; w_D = 2'b00; w_sr = sr; w_sl = sl;
    endtask

    logic [7:0] r;
    logic       rb;

    initial begin
        Rn = 1'b0;
        set_m(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
        c_en = 1'b0; c_mode = 3'b000; c_lo_D = 4'h0; c_hi_D = 4'h0; c_lo_sl = 1'b0; c_hi_sr = 1'b0;
        set_w(1'b0, 3'b000, 1'b0, 1'b0);
        push(0, "reset_main", 8'hA5, 1'b0, 1'b0, 1'b0);
        push(1, "reset_cascade", 8'h00, 1'b0, 1'b0, 1'b1);
        push(2, "reset_w2", 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        Rn = 1'b1;

        set_m(1'b1, 3'b011, 8'h3C, 1'b0, 1'b0); push(0, "load_3C", 8'h3C, 1'b0, 1'b0, 1'b0); tick();

        // Async reset in the middle of a clock-high phase, during an active shift
        set_m(1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #2;
        Rn = 1'b0;
        #1;
        tests++;
        if (m_Q !== 8'hA5 || m_so_r !== 1'b0 || m_so_l !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_direct: got Q=%h so_r=%b so_l=%b, expected Q=a5 so_r=0 so_l=0",
                     m_Q, m_so_r, m_so_l);
        end
        push(0, "async_rst_noclk", 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        push(0, "rst_held_abort", 8'hA5, 1'b0, 1'b0, 1'b0); tick();
        Rn = 1'b1;

        set_m(1'b1, 3'b011, 8'h3C, 1'b0, 1'b0); push(0, "reload_3C", 8'h3C, 1'b0, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b001, 8'h00, 1'b1, 1'b1);
        push(0, "shr1", 8'h9E, 1'b0, 1'b0, 1'b0); tick();
        push(0, "shr2", 8'hCF, 1'b0, 1'b0, 1'b0); tick();
        push(0, "shr3", 8'hE7, 1'b1, 1'b0, 1'b0); tick();
        m_sr = 1'b0;
        push(0, "shr4_sr0", 8'h73, 1'b1, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b000, 8'hFF, 1'b1, 1'b1); push(0, "hold", 8'h73, 1'b1, 1'b0, 1'b0); tick();

        set_m(1'b1, 3'b011, 8'h81, 1'b0, 1'b0); push(0, "load_81", 8'h81, 1'b0, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b010, 8'h00, 1'b1, 1'b0); push(0, "shl", 8'h02, 1'b0, 1'b1, 1'b0); tick();
        set_m(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        r = 8'h02;
        for (int i = 0; i < 8; i++) begin
            rb = r[7];
            r  = {r[6:0], r[7]};
            push(0, "rol", r, 1'b0, rb, 1'b0);
            tick();
        end
        set_m(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
        push(0, "ror1", 8'h01, 1'b0, 1'b0, 1'b0); tick();
        push(0, "ror2", 8'h80, 1'b1, 1'b0, 1'b0); tick();

        set_m(1'b1, 3'b011, 8'h80, 1'b0, 1'b0); push(0, "load_80", 8'h80, 1'b0, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        push(0, "asr_C0", 8'hC0, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_E0", 8'hE0, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_F0", 8'hF0, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_F8", 8'hF8, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_FC", 8'hFC, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_FE", 8'hFE, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_FF", 8'hFF, 1'b0, 1'b0, 1'b0); tick();
        push(0, "asr_sat1", 8'hFF, 1'b1, 1'b0, 1'b0); tick();
        push(0, "asr_sat2", 8'hFF, 1'b1, 1'b0, 1'b0); tick();

        set_m(1'b1, 3'b011, 8'h40, 1'b0, 1'b0); push(0, "load_40", 8'h40, 1'b0, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b110, 8'h00, 1'b1, 1'b0);
        r = 8'h40;
        for (int i = 0; i < 7; i++) begin
            rb = r[0];
            r  = {r[7], r[7:1]};
            push(0, "asr_pos", r, rb, 1'b0, (r == 8'h00));
            tick();
        end

        set_m(1'b1, 3'b011, 8'hAD, 1'b0, 1'b0); push(0, "load_AD", 8'hAD, 1'b0, 1'b0, 1'b0); tick();
        set_m(1'b1, 3'b010, 8'h00, 1'b0, 1'b0); push(0, "shl_AD", 8'h5A, 1'b0, 1'b1, 1'b0); tick();
        set_m(1'b0, 3'b111, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push(0, "en0_clr_held", 8'h5A, 1'b0, 1'b1, 1'b0);
            tick();
        end
        m_en = 1'b1; push(0, "clr", 8'h00, 1'b0, 1'b0, 1'b1); tick();
        tests++;
        if (m_Q !== 8'h00 || m_zero !== 1'b1 || m_so_r !== 1'b0 || m_so_l !== 1'b0) begin
            fails++;
            $display("FAIL clr_direct: got Q=%h zero=%b so_r=%b so_l=%b, expected Q=00 zero=1 so_r=0 so_l=0",
                     m_Q, m_zero, m_so_r, m_so_l);
        end
        m_en = 1'b0;

        // Cascade
        c_en = 1'b1; c_mode = 3'b011; c_lo_D = 4'h1; c_hi_D = 4'h8;
        push(1, "casc_load_81", 8'h81, 1'b0, 1'b0, 1'b0); tick();
        c_mode = 3'b010; c_lo_sl = 1'b0;
        push(1, "casc_shl", 8'h02, 1'b0, 1'b1, 1'b0); tick();
        tests++;
        if ({hi_Q, lo_Q} !== 8'h02 || hi_so_l !== 1'b1) begin
            fails++;
            $display("FAIL casc_shl_direct: got Q=%h so_l=%b, expected Q=02 so_l=1",
                     {hi_Q, lo_Q}, hi_so_l);
        end
        c_mode = 3'b011;
        push(1, "casc_reload_81", 8'h81, 1'b0, 1'b0, 1'b0); tick();
        c_mode = 3'b001; c_hi_sr = 1'b0;
        push(1, "casc_shr", 8'h40, 1'b1, 1'b0, 1'b0); tick();
        c_en = 1'b0;

        // 2-bit instance starting from RST_VAL 2'b10
        set_w(1'b1, 3'b101, 1'b0, 1'b0); push(2, "w2_rol", 8'h01, 1'b0, 1'b1, 1'b0); tick();
        set_w(1'b1, 3'b001, 1'b1, 1'b0); push(2, "w2_shr", 8'h02, 1'b1, 1'b1, 1'b0); tick();
        set_w(1'b1, 3'b110, 1'b0, 1'b0); push(2, "w2_asr", 8'h03, 1'b0, 1'b1, 1'b0); tick();
        set_w(1'b1, 3'b010, 1'b0, 1'b0); push(2, "w2_shl", 8'h02, 1'b0, 1'b1, 1'b0); tick();
        set_w(1'b1, 3'b100, 1'b0, 1'b0); push(2, "w2_ror", 8'h01, 1'b0, 1'b1, 1'b0); tick();
        set_w(1'b1, 3'b111, 1'b0, 1'b0); push(2, "w2_clr", 8'h00, 1'b0, 1'b0, 1'b1); tick();
        tests++;
        if (w_Q !== 2'b00 || w_zero !== 1'b1) begin
            fails++;
            $display("FAIL w2_clr_direct: got Q=%b zero=%b, expected Q=00 zero=1", w_Q, w_zero);
        end
        w_en = 1'b0;

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
